// File: rtl/frac_n_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frac_n_pkg
//  Description : Shared constants and controller state encoding for the
//                240/248 dual-modulus frac-N feedback divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package frac_n_pkg;

  localparam int   DIV_N_LOW  = 240;
  localparam int   DIV_N_HIGH = 248;
  localparam logic SEL_DIV240 = 1'b1;
  localparam logic SEL_DIV248 = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/frac_n_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : frac_n_accumulator
//  Description : First-order phase accumulator with registered carry. One
//                step per divided output period; the carry is the modulus
//                select for the following period.
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_n_accumulator #(
  parameter int FRAC_W = 16
) (
  input  logic              freq_in,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic [FRAC_W-1:0] acc,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [FRAC_W:0]   sum_w;

  // One extra bit captures the overflow; the accumulator itself wraps modulo 2^FRAC_W.
  assign sum_w = {1'b0, acc_q} + {1'b0, frac};

  // Accumulate on each step; clear has priority so an abandoned run restarts from zero.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (clr) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (step) begin
      {carry_q, acc_q} <= sum_w;
    end
  end

  assign acc   = acc_q;
  assign carry = carry_q;

endmodule
`default_nettype wire

// File: rtl/frac_n_modulus_controller.sv
`default_nettype none
// ============================================================================
//  Module      : frac_n_modulus_controller
//  Description : MASH-1 modulus controller for the 240/248 divider. Sequences
//                divider reset/start, detects divider output edges, steps the
//                accumulator and handles fractional-word updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module frac_n_modulus_controller
  import frac_n_pkg::*;
#(
  parameter int FRAC_W     = 16,
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic              freq_in,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              freq_out_div,
  input  logic              cfg_valid,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_ready,
  output logic              select_mode,
  output logic              div_reset,
  output logic              running,
  output logic [CNT_W-1:0]  period_count
);

  localparam int              SC_W    = $clog2(RST_CYCLES);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(RST_CYCLES - 1);

  ctrl_state_t       state_q, state_d;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic              fod_q;
  logic              div_reset_q;
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] pend_q;
  logic              pend_vld_q;
  logic [CNT_W-1:0]  pcnt_q;

  logic              div_edge_w;
  logic              step_w;
  logic              clr_w;
  logic              xfer_w;
  logic              stay_run_w;
  logic              carry_w;
  logic [FRAC_W-1:0] acc_unused;

  assign div_edge_w = freq_out_div & ~fod_q;
  assign stay_run_w = (state_q == RUN) && (state_d == RUN);
  assign step_w     = div_edge_w && (state_q == RUN);
  // Anything not continuing in RUN (including the exit cycle) clears the run state.
  assign clr_w      = (state_d != RUN);
  assign cfg_ready  = ~pend_vld_q;
  assign xfer_w     = cfg_valid & cfg_ready;

  // State register and START-phase cycle counter.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // Next-state logic: START lasts exactly RST_CYCLES cycles while enable stays high.
  always_comb begin
    state_d = state_q;
    scnt_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = START;
      end
      START: begin
        if (!enable)               state_d = IDLE;
        else if (scnt_q == SC_LAST) state_d = RUN;
        else                       scnt_d  = scnt_q + 1'b1;
      end
      RUN: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Divider reset is a flop so it cannot glitch; it follows the upcoming state.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      div_reset_q <= 1'b1;
      fod_q       <= 1'b0;
    end else begin
      div_reset_q <= (state_d != RUN);
      fod_q       <= freq_out_div;
    end
  end

  // Fractional word: direct load outside RUN, deferred via pending register in RUN.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n) begin
      frac_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (!stay_run_w) begin
      if (pend_vld_q) begin
        frac_q     <= pend_q;
        pend_vld_q <= 1'b0;
      end else if (xfer_w) begin
        frac_q <= cfg_frac;
      end
    end else begin
      // The edge that applies the pending word still accumulates with the old one.
      if (step_w && pend_vld_q) begin
        frac_q     <= pend_q;
        pend_vld_q <= 1'b0;
      end
      if (xfer_w) begin
        pend_q     <= cfg_frac;
        pend_vld_q <= 1'b1;
      end
    end
  end

  // Count completed divided periods since entering RUN.
  always_ff @(posedge freq_in or negedge reset_n) begin
    if (!reset_n)    pcnt_q <= '0;
    else if (clr_w)  pcnt_q <= '0;
    else if (step_w) pcnt_q <= pcnt_q + 1'b1;
  end

  frac_n_accumulator #(
    .FRAC_W (FRAC_W)
  ) u_acc (
    .freq_in (freq_in),
    .reset_n (reset_n),
    .clr     (clr_w),
    .step    (step_w),
    .frac    (frac_q),
    .acc     (acc_unused),
    .carry   (carry_w)
  );

  assign select_mode  = carry_w ? SEL_DIV240 : SEL_DIV248;
  assign div_reset    = div_reset_q;
  assign running      = (state_q == RUN);
  assign period_count = pcnt_q;

endmodule
`default_nettype wire
